// File: rtl/fp_mul_pkg.sv
// ============================================================================
//  Module   : fp_mul_pkg
//  Purpose  : Shared state encoding, format defaults and format-derived
//             constants for the sequential floating-point multiplier.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_mul_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in a 64-bit word.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mant_mul_seq.sv
// ============================================================================
//  Module   : fp_mant_mul_seq
//  Purpose  : Shift-add significand multiplier, one multiplier bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_mant_mul_seq #(
    parameter int MAN_W = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [MAN_W:0]             a_i,
    input  logic [MAN_W:0]             b_i,
    output logic                       done_o,
    output logic [2*(MAN_W+1)-1:0]     product_o
);

    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    logic [PW-1:0] mcand_q;
    logic [N-1:0]  mplier_q;
    logic [PW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic          active_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{N{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == c_LAST) begin
                active_q <= 1'b0;
            end
        end
    end

    // done marks the cycle whose closing edge adds the final partial product.
    assign done_o    = active_q && (cnt_q == c_LAST);
    assign product_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/fp_mul_param_seq.sv
// ============================================================================
//  Module   : fp_mul_param_seq
//  Purpose  : Parameterised sequential IEEE-style multiplier, truncating,
//             flush-to-zero, with valid/accept handshakes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_mul_param_seq
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    input  logic                     inReady,
    output logic                     inAccept,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     resultReady,
    input  logic                     resultAccepted,
    output logic                     busy
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] c_BIAS    = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] c_EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] c_ONE     = EW'(1);
    localparam logic signed [EW-1:0] c_ZERO    = '0;
    localparam logic [63:0]          c_QNAN64  = fp_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         c_QNAN    = c_QNAN64[W-1:0];

    state_t state_q, state_d;

    logic [W-1:0]  a_q, b_q;
    logic [W-1:0]  result_q, result_d;
    logic          w_capture;
    logic          w_mul_done;
    logic [PW-1:0] w_prod;
    logic [N-1:0]  w_sig_a, w_sig_b;

    assign w_capture = (state_q == S_IDLE) && inReady;
    assign w_sig_a   = {|A[MAN_W +: EXP_W], A[MAN_W-1:0]};
    assign w_sig_b   = {|B[MAN_W +: EXP_W], B[MAN_W-1:0]};

    fp_mant_mul_seq #(
        .MAN_W (MAN_W)
    ) u_mant_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (w_capture),
        .a_i       (w_sig_a),
        .b_i       (w_sig_b),
        .done_o    (w_mul_done),
        .product_o (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (w_capture) begin
                a_q <= A;
                b_q <= B;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (inReady)        state_d = S_MUL;
            S_MUL:  if (w_mul_done)     state_d = S_NORM;
            S_NORM:                     state_d = S_DONE;
            S_DONE: if (resultAccepted) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    assign inAccept    = (state_q == S_IDLE);
    assign busy        = (state_q == S_MUL) || (state_q == S_NORM);
    assign resultReady = (state_q == S_DONE);
    assign result      = result_q;

    // Operand classification and exponent path.
    logic [EXP_W-1:0]        w_ea, w_eb;
    logic                    w_sign;
    logic                    w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic signed [EW-1:0]    w_exp_sum, w_exp_adj;
    logic [MAN_W-1:0]        w_frac;
    logic [MAN_W-1:0]        w_unused_lsbs;

    assign w_ea     = a_q[MAN_W +: EXP_W];
    assign w_eb     = b_q[MAN_W +: EXP_W];
    assign w_sign   = a_q[W-1] ^ b_q[W-1];
    assign w_nan_a  = (&w_ea) && (|a_q[MAN_W-1:0]);
    assign w_nan_b  = (&w_eb) && (|b_q[MAN_W-1:0]);
    assign w_inf_a  = (&w_ea) && !(|a_q[MAN_W-1:0]);
    assign w_inf_b  = (&w_eb) && !(|b_q[MAN_W-1:0]);
    assign w_zero_a = !(|w_ea);
    assign w_zero_b = !(|w_eb);

    assign w_exp_sum     = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_BIAS;
    assign w_exp_adj     = w_prod[PW-1] ? (w_exp_sum + c_ONE) : w_exp_sum;
    assign w_frac        = w_prod[PW-1] ? w_prod[PW-2 -: MAN_W] : w_prod[PW-3 -: MAN_W];
    assign w_unused_lsbs = w_prod[MAN_W-1:0];

    always_comb begin
        result_d = result_q;
        if (state_q == S_NORM) begin
            if (w_nan_a || w_nan_b || (w_zero_a && w_inf_b) || (w_inf_a && w_zero_b)) begin
                result_d = c_QNAN;
            end else if (w_inf_a || w_inf_b) begin
                result_d = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (w_zero_a || w_zero_b) begin
                result_d = {w_sign, {(W-1){1'b0}}};
            end else if (w_exp_adj >= c_EXP_MAX) begin
                result_d = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (w_exp_adj <= c_ZERO) begin
                result_d = {w_sign, {(W-1){1'b0}}};
            end else begin
                result_d = {w_sign, w_exp_adj[EXP_W-1:0], w_frac};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_param_seq.sv
// ============================================================================
//  Module   : tb_fp_mul_param_seq
//  Purpose  : Directed self-checking bench, single- and half-format instances.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_param_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] s_a = '0, s_b = '0, s_result;
    logic        s_in_ready = 1'b0, s_in_accept, s_result_ready;
    logic        s_result_accepted = 1'b0, s_busy;

    logic [15:0] h_a = '0, h_b = '0, h_result;
    logic        h_in_ready = 1'b0, h_in_accept, h_result_ready;
    logic        h_result_accepted = 1'b0, h_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_mul_param_seq u_dut_sp (
        .clk            (clk),
        .rst            (rst),
        .A              (s_a),
        .B              (s_b),
        .inReady        (s_in_ready),
        .inAccept       (s_in_accept),
        .result         (s_result),
        .resultReady    (s_result_ready),
        .resultAccepted (s_result_accepted),
        .busy           (s_busy)
    );

    fp_mul_param_seq #(
        .EXP_W (5),
        .MAN_W (10)
    ) u_dut_hp (
        .clk            (clk),
        .rst            (rst),
        .A              (h_a),
        .B              (h_b),
        .inReady        (h_in_ready),
        .inAccept       (h_in_accept),
        .result         (h_result),
        .resultReady    (h_result_ready),
        .resultAccepted (h_result_accepted),
        .busy           (h_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sp_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        s_a        = a;
        s_b        = b;
        s_in_ready = 1'b1;
        @(posedge clk);
        #1 s_in_ready = 1'b0;
    endtask

    // Counts edges from the capture edge until resultReady is seen.
    task automatic sp_wait_done(output int lat);
        lat = 0;
        while (!s_result_ready && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic sp_accept();
        @(negedge clk);
        s_result_accepted = 1'b1;
        @(posedge clk);
        #1 s_result_accepted = 1'b0;
    endtask

    task automatic sp_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int lat;
        sp_start(a, b);
        sp_wait_done(lat);
        check({tag, "_result"}, 64'(s_result), 64'(exp));
        check({tag, "_latency"}, 64'(lat), 64'd25);
        sp_accept();
    endtask

    initial begin
        int          lat;
        logic [31:0] snap;
        logic        bp_err;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_inAccept",    64'(s_in_accept),    64'd1);
        check("rst_resultReady", 64'(s_result_ready), 64'd0);
        check("rst_busy",        64'(s_busy),         64'd0);
        check("rst_result",      64'(s_result),       64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Main function: -2.25 * 4.5, with busy observed mid-run.
        sp_start(32'hC010_0000, 32'h4090_0000);
        check("mul_busy",     64'(s_busy),      64'd1);
        check("mul_inAccept", 64'(s_in_accept), 64'd0);
        sp_wait_done(lat);
        check("neg_result",  64'(s_result), 64'hC122_0000);
        check("neg_latency", 64'(lat),      64'd25);
        check("done_busy",   64'(s_busy),   64'd0);
        sp_accept();
        check("acc_inAccept", 64'(s_in_accept), 64'd1);

        sp_op("no_norm",  32'h4040_0000, 32'hBF00_0000, 32'hBFC0_0000);
        sp_op("zero_inf", 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000);
        sp_op("ovf",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
        sp_op("unf",      32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        sp_op("subn",     32'h8000_0001, 32'h3F80_0000, 32'h8000_0000);
        sp_op("nan_in",   32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        sp_op("inf_neg",  32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000);

        // Half-precision instance: 1.5 * 1.5.
        @(negedge clk);
        h_a        = 16'h3E00;
        h_b        = 16'h3E00;
        h_in_ready = 1'b1;
        @(posedge clk);
        #1 h_in_ready = 1'b0;
        lat = 0;
        while (!h_result_ready && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("hp_result",  64'(h_result), 64'h4080);
        check("hp_latency", 64'(lat),      64'd12);
        @(negedge clk);
        h_result_accepted = 1'b1;
        @(posedge clk);
        #1 h_result_accepted = 1'b0;

        // Backpressure: new request ignored while result is held.
        sp_start(32'hC010_0000, 32'h4090_0000);
        sp_wait_done(lat);
        snap   = s_result;
        bp_err = 1'b0;
        @(negedge clk);
        s_a        = 32'h3F80_0000;
        s_b        = 32'h3F80_0000;
        s_in_ready = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (s_result !== snap || s_in_accept !== 1'b0 || s_result_ready !== 1'b1)
                bp_err = 1'b1;
        end
        check("bp_hold_err", 64'(bp_err),   64'd0);
        check("bp_result",   64'(s_result), 64'hC122_0000);
        @(negedge clk);
        s_in_ready = 1'b0;
        sp_accept();
        check("bp_rel_inAccept",    64'(s_in_accept),    64'd1);
        check("bp_rel_resultReady", 64'(s_result_ready), 64'd0);

        // Reset during MUL, overriding a pending request.
        sp_start(32'h4040_0000, 32'h4040_0000);
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 64'(s_busy), 64'd1);
        @(negedge clk);
        rst               = 1'b1;
        s_in_ready        = 1'b1;
        s_result_accepted = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_inAccept",    64'(s_in_accept),    64'd1);
        check("mid_rst_resultReady", 64'(s_result_ready), 64'd0);
        check("mid_rst_busy",        64'(s_busy),         64'd0);
        check("mid_rst_result",      64'(s_result),       64'd0);
        @(negedge clk);
        rst               = 1'b0;
        s_in_ready        = 1'b0;
        s_result_accepted = 1'b0;
        sp_op("post_rst", 32'hC010_0000, 32'h4090_0000, 32'hC122_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
